// File: rtl/compressed_encoder.sv
// Packs RV32 instructions into 32-bit fetch words and converts eligible ones to RVC halfwords.
// Defining COMPRESSED_ENCODER_STACK_EN adds the sp-relative c.lwsp / c.swsp forms.
module compressed_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic [15:0] cnt_comp_o
);
  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] ph_q, ph_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic [15:0] cnt_q, cnt_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_i, imm_s;
  logic        imm_i_6b, rd_p, rs1_p, rs2_p;
  logic [1:0]  alu_sel;
  logic        hit, is16;
  logic [15:0] c16;
  logic        slot_free, in_fire;

  assign opc   = in_instr_i[6:0];
  assign rd    = in_instr_i[11:7];
  assign f3    = in_instr_i[14:12];
  assign rs1   = in_instr_i[19:15];
  assign rs2   = in_instr_i[24:20];
  assign f7    = in_instr_i[31:25];
  assign imm_i = in_instr_i[31:20];
  assign imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

  // Signed 12-bit immediate fits in 6 bits when the top 7 bits are all sign copies.
  assign imm_i_6b = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
  assign rd_p     = (rd[4:3] == 2'b01);
  assign rs1_p    = (rs1[4:3] == 2'b01);
  assign rs2_p    = (rs2[4:3] == 2'b01);

  always_comb begin
    alu_sel = 2'b00;
    case (f3)
      3'b100:  alu_sel = 2'b01;
      3'b110:  alu_sel = 2'b10;
      3'b111:  alu_sel = 2'b11;
      default: alu_sel = 2'b00;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    c16 = in_instr_i[15:0];
    if (opc == 7'h13 && f3 == 3'b000) begin
      if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
        hit = 1'b1;
        c16 = 16'h0001;
      end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && imm_i_6b) begin
        hit = 1'b1;
        c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (rd != 5'd0 && rs1 == 5'd0 && imm_i_6b) begin
        hit = 1'b1;
        c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end
    end else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
      if (rs1 == 5'd0) begin
        hit = 1'b1;
        c16 = {4'b1000, rd, rs2, 2'b10};
      end else if (rs1 == rd) begin
        hit = 1'b1;
        c16 = {4'b1001, rd, rs2, 2'b10};
      end
    end else if (opc == 7'h67 && f3 == 3'b000 && rd == 5'd0 && imm_i == 12'd0 && rs1 != 5'd0) begin
      hit = 1'b1;
      c16 = {4'b1000, rs1, 5'd0, 2'b10};
    end else if (opc == 7'h33 && rd == rs1 && rd_p && rs2_p &&
                 ((f7 == 7'h20 && f3 == 3'b000) ||
                  (f7 == 7'h00 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)))) begin
      hit = 1'b1;
      c16 = {6'b100011, rd[2:0], alu_sel, rs2[2:0], 2'b01};
    end else if (opc == 7'h03 && f3 == 3'b010) begin
      if (rd_p && rs1_p && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
        hit = 1'b1;
        c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
      end
`ifdef COMPRESSED_ENCODER_STACK_EN
      else if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00) begin
        hit = 1'b1;
        c16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
      end
`endif
    end else if (opc == 7'h23 && f3 == 3'b010) begin
      if (rs2_p && rs1_p && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
        hit = 1'b1;
        c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      end
`ifdef COMPRESSED_ENCODER_STACK_EN
      else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00) begin
        hit = 1'b1;
        c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
      end
`endif
    end
  end

  // Opcodes checked above all end in 2'b11, so hit never fires on a pre-compressed halfword.
  assign is16      = (in_instr_i[1:0] != 2'b11) || hit;
  assign slot_free = !out_valid_q || out_ready_i;
  assign in_ready_o = !rst_i && !flush_i && slot_free;
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_word_d  = out_word_q;
    cnt_d       = cnt_q;
    if (in_fire) begin
      if (hit && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (state_q == EMPTY) begin
        if (is16) begin
          ph_d    = c16;
          state_d = HALF;
        end else begin
          out_valid_d = 1'b1;
          out_word_d  = in_instr_i;
        end
      end else begin
        out_valid_d = 1'b1;
        if (is16) begin
          out_word_d = {c16, ph_q};
          state_d    = EMPTY;
        end else begin
          out_word_d = {in_instr_i[15:0], ph_q};
          ph_d       = in_instr_i[31:16];
        end
      end
    end else if (flush_i && state_q == HALF && slot_free) begin
      out_valid_d = 1'b1;
      out_word_d  = {16'h0001, ph_q};
      state_d     = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      ph_q        <= 16'd0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign cnt_comp_o  = cnt_q;
endmodule

// File: tb/tb_compressed_encoder.sv
// Scoreboard bench for compressed_encoder: halfword-stream reference model plus randomized traffic.
module tb_compressed_encoder;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_word_o;
  logic [15:0] cnt_comp_o;

  compressed_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_word_o(out_word_o), .cnt_comp_o(cnt_comp_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [15:0] hw_q[$];
  logic [31:0] sb_q[$];
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference compression built from field values and RVC bit weights.
  function automatic bit ref_comp(input logic [31:0] i, output logic [15:0] c);
    int op, rd, rs1, rs2, f3, f7, immi, imms, v;
    op = int'(i[6:0]); rd = int'(i[11:7]); f3 = int'(i[14:12]);
    rs1 = int'(i[19:15]); rs2 = int'(i[24:20]); f7 = int'(i[31:25]);
    immi = int'($signed(i[31:20]));
    imms = int'($signed({i[31:25], i[11:7]}));
    v = -1;
    if (op == 19 && f3 == 0) begin
      if (rd == 0 && rs1 == 0 && immi == 0) v = 1;
      else if (rd != 0 && rs1 == rd && immi != 0 && immi >= -32 && immi <= 31)
        v = ((immi >> 5) & 1) * 4096 + rd * 128 + (immi & 31) * 4 + 1;
      else if (rd != 0 && rs1 == 0 && immi >= -32 && immi <= 31)
        v = 2 * 8192 + ((immi >> 5) & 1) * 4096 + rd * 128 + (immi & 31) * 4 + 1;
    end else if (op == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == 0)
      v = 'h8002 + rd * 128 + rs2 * 4;
    else if (op == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == rd)
      v = 'h9002 + rd * 128 + rs2 * 4;
    else if (op == 103 && f3 == 0 && rd == 0 && immi == 0 && rs1 != 0)
      v = 'h8002 + rs1 * 128;
    else if (op == 51 && rd == rs1 && rd >= 8 && rd <= 15 && rs2 >= 8 && rs2 <= 15) begin
      if (f7 == 32 && f3 == 0) v = 'h8C01 + (rd - 8) * 128 + 0 * 32 + (rs2 - 8) * 4;
      else if (f7 == 0 && f3 == 4) v = 'h8C01 + (rd - 8) * 128 + 1 * 32 + (rs2 - 8) * 4;
      else if (f7 == 0 && f3 == 6) v = 'h8C01 + (rd - 8) * 128 + 2 * 32 + (rs2 - 8) * 4;
      else if (f7 == 0 && f3 == 7) v = 'h8C01 + (rd - 8) * 128 + 3 * 32 + (rs2 - 8) * 4;
    end else if (op == 3 && f3 == 2) begin
      if (rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && immi >= 0 && immi <= 124 && immi % 4 == 0)
        v = 'h4000 + ((immi >> 3) & 7) * 1024 + (rs1 - 8) * 128 + ((immi >> 2) & 1) * 64 + ((immi >> 6) & 1) * 32 + (rd - 8) * 4;
`ifdef COMPRESSED_ENCODER_STACK_EN
      else if (rs1 == 2 && rd != 0 && immi >= 0 && immi <= 252 && immi % 4 == 0)
        v = 'h4002 + ((immi >> 5) & 1) * 4096 + rd * 128 + ((immi >> 2) & 7) * 16 + ((immi >> 6) & 3) * 4;
`endif
    end else if (op == 35 && f3 == 2) begin
      if (rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && imms >= 0 && imms <= 124 && imms % 4 == 0)
        v = 'hC000 + ((imms >> 3) & 7) * 1024 + (rs1 - 8) * 128 + ((imms >> 2) & 1) * 64 + ((imms >> 6) & 1) * 32 + (rs2 - 8) * 4;
`ifdef COMPRESSED_ENCODER_STACK_EN
      else if (rs1 == 2 && imms >= 0 && imms <= 252 && imms % 4 == 0)
        v = 'hC002 + ((imms >> 2) & 15) * 512 + ((imms >> 6) & 3) * 128 + rs2 * 4;
`endif
    end
    c = (v < 0) ? i[15:0] : 16'(v);
    return (v >= 0);
  endfunction

  // Every accepted instruction appends halfwords to a program-order stream; pairs become words.
  task automatic model_accept(input logic [31:0] ins);
    logic [15:0] c;
    if (ins[1:0] != 2'b11) hw_q.push_back(ins[15:0]);
    else if (ref_comp(ins, c)) begin
      hw_q.push_back(c);
      if (m_cnt < 65535) m_cnt++;
    end else begin
      hw_q.push_back(ins[15:0]);
      hw_q.push_back(ins[31:16]);
    end
    while (hw_q.size() >= 2) begin
      sb_q.push_back({hw_q[1], hw_q[0]});
      hw_q.pop_front();
      hw_q.pop_front();
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic rdy, input logic rs);
    logic exp_ready;
    in_valid_i = v; in_instr_i = ins; flush_i = fl; out_ready_i = rdy; rst_i = rs;
    @(negedge clk_i);
    exp_ready = !rs && !fl && (sb_q.size() == 0 || rdy);
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, sb_q.size() != 0});
    chk("cnt_comp", {16'd0, cnt_comp_o}, 32'(m_cnt));
    if (sb_q.size() != 0) chk("held_word", out_word_o, sb_q[0]);
    if (rs) begin
      hw_q.delete();
      sb_q.delete();
      m_cnt = 0;
    end else if (v && exp_ready) model_accept(ins);
    else if (fl && hw_q.size() == 1 && (sb_q.size() == 0 || rdy)) begin
      sb_q.push_back({16'h0001, hw_q[0]});
      hw_q.pop_front();
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (out_valid_o && out_ready_i && !rst_i) begin
        if (sb_q.size() == 0) chk("unexpected_word", out_word_o, 32'hxxxxxxxx);
        else chk("out_word", out_word_o, sb_q.pop_front());
      end
    end
  end

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd2;
      2: return 5'($urandom_range(0, 31));
      default: return 5'(8 + $urandom_range(0, 7));
    endcase
  endfunction

  function automatic logic [11:0] pick_imm();
    case ($urandom_range(0, 3))
      0: return 12'(int'($urandom_range(0, 80)) - 40);
      1: return 12'(4 * $urandom_range(0, 66));
      2: return 12'($urandom_range(0, 260));
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0] f3;
    rd = pick_reg(); rs2 = pick_reg(); imm = pick_imm();
    case ($urandom_range(0, 3))
      0: rs1 = rd;
      1: rs1 = 5'd0;
      2: rs1 = 5'd2;
      default: rs1 = pick_reg();
    endcase
    case ($urandom_range(0, 2))
      0: f3 = 3'b100;
      1: f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    case ($urandom_range(0, 8))
      0: return {imm, rs1, 3'b000, rd, 7'h13};
      1: return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      2: return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      3: return {7'h00, rs2, rs1, f3, rd, 7'h33};
      4: return {imm, rs1, 3'b010, rd, 7'h03};
      5: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      6: return {imm, rs1, 3'b000, 5'd0, 7'h67};
      7: return {16'($urandom), 14'($urandom), 2'($urandom_range(0, 2))};
      default: return $urandom;
    endcase
  endfunction

  logic rs_r;

  initial begin
    @(posedge clk_i);
    #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // add/addi pair packs into one word
    step(1, 32'h00108093, 0, 1, 0);
    step(1, 32'h00B50533, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("cnt_pair", {16'd0, cnt_comp_o}, 32'd2);
    // uncompressible lui from EMPTY
    step(1, 32'h123452B7, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("cnt_lui", {16'd0, cnt_comp_o}, 32'd2);
    // split word then flush
    step(1, 32'h00108093, 0, 1, 0);
    step(1, 32'h123452B7, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    // lw x8,8(x2): stack form depends on build
    step(1, 32'h00812403, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    // backpressure hold for 5 cycles then release
    step(1, 32'h123452B7, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 32'h00B50533, 0, 0, 0);
    step(1, 32'h00B50533, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    // reset discards pending c.nop
    step(1, 32'h00000013, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("cnt_after_rst", {16'd0, cnt_comp_o}, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      rs_r = ($urandom_range(0, 299) == 0);
      step(1'($urandom_range(0, 3) != 0), gen(), 1'($urandom_range(0, 15) == 0),
           rs_r ? 1'b0 : 1'($urandom_range(0, 3) != 0), rs_r);
    end
    for (int n = 0; n < 4; n++) step(0, 0, 1, 1, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
